pcie_rq_arbiter: RTL
====================

// Module: pcie_rq_arbiter
// PURPOSE
//   Shares the single PCIe requester-request (RQ) AXIS port between N_REQ requesters: configurator, NVMe cmd issuer, doorbell writer.
//   Round-robin arbitration at packet granularity; the grant is held from first beat to tlast.
//   Stamps the requester index into tag[7:6] of each descriptor.
//   Routes requester-completion (RC) packets back to the owning requester by tag[7:6].
// PARAMETERS
//   C_DATA_WIDTH         128  AXIS data width; only 128 is supported
//   KEEP_WIDTH           C_DATA_WIDTH/32  tkeep width
//   AXI4_RQ_TUSER_WIDTH  62   RQ tuser width
//   AXI4_RC_TUSER_WIDTH  75   RC tuser width
//   N_REQ                3    number of requesters, 2..4 (index fits in tag[7:6])
// PORTS
//   Clock is user_clk and reset is user_reset: one clock; reset is synchronous and active-high.
//   user_clk          in   1                 single clock
//   user_reset        in   1                 sync active-high reset
//   user_lnk_up       in   1                 0 is treated exactly as reset
//   req_tdata         in   N_REQ*128         packed RQ data, requester i at [i*128 +: 128]
//   req_tuser         in   N_REQ*62          packed RQ tuser
//   req_tkeep         in   N_REQ*4           packed RQ tkeep
//   req_tlast         in   N_REQ             per-requester tlast
//   req_tvalid        in   N_REQ             per-requester tvalid
//   req_tready        out  N_REQ             per-requester tready
//   s_axis_rq_tdata   out  128               to PCIe core
//   s_axis_rq_tuser   out  62                to PCIe core
//   s_axis_rq_tkeep   out  4                 to PCIe core
//   s_axis_rq_tlast   out  1                 to PCIe core
//   s_axis_rq_tvalid  out  1                 to PCIe core
//   s_axis_rq_tready  in   4                 from core; only bit 0 is used
//   m_axis_rc_tdata   in   128               from PCIe core
//   m_axis_rc_tuser   in   75                from PCIe core
//   m_axis_rc_tkeep   in   4                 from PCIe core
//   m_axis_rc_tlast   in   1                 from PCIe core
//   m_axis_rc_tvalid  in   1                 from PCIe core
//   m_axis_rc_tready  out  1                 to PCIe core
//   rc_tdata/tuser/tkeep/tlast  out  broadcast  RC payload fanned out to all requesters
//   rc_tvalid         out  N_REQ             one-hot, valid only for the owning requester
//   rc_tready         in   N_REQ             per-requester ready
//   grant             out  N_REQ             one-hot current RQ owner; 0 when idle
//   rc_misroute       out  1                 1-cycle pulse on an RC sop whose tag[7:6] >= N_REQ
// BEHAVIOUR
//   Reset (user_reset | !user_lnk_up), applied in any state, including mid-packet:
//   - RQ FSM -> IDLE; RC FSM -> RC_IDLE; rr pointer -> 0.
//   - grant, req_tready, s_axis_rq_tvalid, rc_tvalid, rc_misroute -> 0; m_axis_rc_tready -> 0.
//   - A partial packet is simply dropped; the core's reset handles it.
//   RQ FSM, states IDLE and PASS:
//   - IDLE: if any req_tvalid is set, register a one-hot grant (rr pick starting at ptr) and go to PASS.
//     No beat is forwarded in the grant cycle, so request-to-first-beat latency is 1 cycle.
//   - PASS: the s_axis_rq_* outputs are combinational mux of the granted requester (zero extra latency).
//     req_tready[g] = s_axis_rq_tready[0]; every other req_tready = 0.
//   - A beat is accepted when tvalid & tready[0].
//   - The first beat of each packet (sop flag, set by the grant) has tdata[103:102] overwritten with index g.
//     Non-first beats pass through unmodified.
//   - On accept with tlast: ptr <= g+1 mod N_REQ; grant -> 0; go to IDLE. Back-to-back packets therefore carry a 1-cycle gap.
//   - tvalid drop mid-packet: hold the grant and stall; no timeout.
//   RC FSM, states RC_IDLE and RC_PASS:
//   - On an RC sop beat, take owner = tdata[71:70].
//     rc_tvalid[owner] = m_axis_rc_tvalid; m_axis_rc_tready = rc_tready[owner].
//   - owner is latched in an owner register for the following beats. Remain in RC_PASS until the tlast beat is accepted.
//   - tag[7:6] is not restored; requesters must compare only tag[5:0].
//   - owner >= N_REQ: the whole packet is consumed with m_axis_rc_tready=1, no rc_tvalid is asserted, and rc_misroute pulses on sop.
//   - The RQ and RC paths are independent; simultaneous RQ grant and RC delivery are legal.
//   Arithmetic and width rules: ptr is clog2(N_REQ) bits and wraps to 0 after N_REQ-1. Requesters own tag[5:0] only; arbiter-side tags are 8 bits.
// STRUCTURE
//   Shared header nvme_pcie_defs.vh holds:
//   - RQ tag field offset 96, RC tag offset 64, owner field width 2.
//   - State encodings for the RQ and RC FSMs.
//   - MemRd/MemWr/CfgRd/CfgWr request-type codes.
//   Sub-module rr_arbiter (N, req[N-1:0], ptr -> one-hot gnt): pure combinational rotate-priority pick.
// TESTING
//   1. Single requester 0, 1-beat MemRd with tag 8'h05 -> core sees tag 8'h05, tlast, grant=001 for 1 beat, then grant=000.
//   2. All 3 requesters continuously valid with 2-beat MemWr -> packets served in order 0,1,2,0; no interleaved beats; 1 idle cycle between packets.
//   3. Core tready[0] toggles 1010 during a 2-beat CfgWr from requester 1 -> both beats delivered in order; req_tready[1] mirrors tready[0].
//   4. RC with tdata[71:64]=8'h83, requester 2 rc_tready=0 for 3 cycles -> rc_tvalid=100 stalls, m_axis_rc_tready=0, then delivered on release.
//   5. RC with tag[7:6]=3 while N_REQ=3 -> packet consumed, rc_tvalid stays 000, rc_misroute pulses once.
//   6. user_lnk_up falls mid-packet in PASS -> next cycle grant=0 and all tvalid/tready outputs 0; the first request after link-up is granted to requester 0.

Source files
------------

// File: rtl/pcie_rq_arbiter_pkg.sv
// Shared definitions for the PCIe RQ/RC arbiter: descriptor field offsets,
// FSM state encodings and request-type codes.
package pcie_rq_arbiter_pkg;

    // Tag field offsets inside the 128-bit RQ / RC descriptors
    localparam int RQ_TAG_OFF = 96;
    localparam int RC_TAG_OFF = 64;
    // Requester index lives in tag[7:6]
    localparam int OWN_LSB    = 6;
    localparam int OWN_W      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } rq_state_e;

    typedef enum logic {
        RC_IDLE = 1'b0,
        RC_PASS = 1'b1
    } rc_state_e;

    typedef enum logic [3:0] {
        REQ_MEMRD = 4'b0000,
        REQ_MEMWR = 4'b0001,
        REQ_CFGRD = 4'b1000,
        REQ_CFGWR = 4'b1010
    } req_type_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: scans req starting at ptr and
// returns a one-hot gnt (all zero when no request). Ports: req, ptr, gnt.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    // Outer loop is priority rank, inner loop keeps every index constant
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] &&
                    (((int'(ptr) + i) % N) == j)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// Shares the PCIe RQ AXIS port between N_REQ requesters (packet-level
// round robin, requester index stamped into tag[7:6]) and routes RC
// packets back to their owner by tag[7:6].
// Ports: user_clk/user_reset/user_lnk_up; req_* requester RQ streams;
// s_axis_rq_* to core; m_axis_rc_* from core; rc_* to requesters;
// grant (one-hot RQ owner); rc_misroute (pulse on bad RC owner).
module pcie_rq_arbiter
    import pcie_rq_arbiter_pkg::*;
#(
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 62,
    parameter int AXI4_RC_TUSER_WIDTH = 75,
    parameter int N_REQ               = 3
) (
    input  logic                                 user_clk,
    input  logic                                 user_reset,
    input  logic                                 user_lnk_up,
    input  logic [N_REQ*C_DATA_WIDTH-1:0]        req_tdata,
    input  logic [N_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
    input  logic [N_REQ*KEEP_WIDTH-1:0]          req_tkeep,
    input  logic [N_REQ-1:0]                     req_tlast,
    input  logic [N_REQ-1:0]                     req_tvalid,
    output logic [N_REQ-1:0]                     req_tready,
    output logic [C_DATA_WIDTH-1:0]              s_axis_rq_tdata,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0]       s_axis_rq_tuser,
    output logic [KEEP_WIDTH-1:0]                s_axis_rq_tkeep,
    output logic                                 s_axis_rq_tlast,
    output logic                                 s_axis_rq_tvalid,
    input  logic [3:0]                           s_axis_rq_tready,
    input  logic [C_DATA_WIDTH-1:0]              m_axis_rc_tdata,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0]       m_axis_rc_tuser,
    input  logic [KEEP_WIDTH-1:0]                m_axis_rc_tkeep,
    input  logic                                 m_axis_rc_tlast,
    input  logic                                 m_axis_rc_tvalid,
    output logic                                 m_axis_rc_tready,
    output logic [C_DATA_WIDTH-1:0]              rc_tdata,
    output logic [AXI4_RC_TUSER_WIDTH-1:0]       rc_tuser,
    output logic [KEEP_WIDTH-1:0]                rc_tkeep,
    output logic                                 rc_tlast,
    output logic [N_REQ-1:0]                     rc_tvalid,
    input  logic [N_REQ-1:0]                     rc_tready,
    output logic [N_REQ-1:0]                     grant,
    output logic                                 rc_misroute
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW = C_DATA_WIDTH;
    localparam int QW = AXI4_RQ_TUSER_WIDTH;
    localparam int KW = KEEP_WIDTH;

    logic             rst;
    rq_state_e        rq_state, rq_state_d;
    rc_state_e        rc_state, rc_state_d;
    logic [N_REQ-1:0] grant_q, pick;
    logic [PW-1:0]    gidx, pick_idx, ptr;
    logic             sop;
    logic             rq_acc;
    logic [OWN_W-1:0] rc_own, own_q;
    logic             rc_mis, rc_acc;
    logic             unused_tready;

    // Link-down behaves exactly like reset
    assign rst           = user_reset | ~user_lnk_up;
    assign grant         = grant_q;
    assign unused_tready = ^s_axis_rq_tready[3:1];

    assign rc_tdata = m_axis_rc_tdata;
    assign rc_tuser = m_axis_rc_tuser;
    assign rc_tkeep = m_axis_rc_tkeep;
    assign rc_tlast = m_axis_rc_tlast;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req (req_tvalid),
        .ptr (ptr),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick[i]) pick_idx = PW'(i);
    end

    // RQ path: combinational mux of the granted requester
    always_comb begin
        rq_state_d       = rq_state;
        s_axis_rq_tdata  = '0;
        s_axis_rq_tuser  = '0;
        s_axis_rq_tkeep  = '0;
        s_axis_rq_tlast  = 1'b0;
        s_axis_rq_tvalid = 1'b0;
        req_tready       = '0;
        rq_acc           = 1'b0;
        if (!rst) begin
            unique case (rq_state)
                IDLE: if (|req_tvalid) rq_state_d = PASS;
                PASS: begin
                    s_axis_rq_tdata  = req_tdata[gidx*DW +: DW];
                    s_axis_rq_tuser  = req_tuser[gidx*QW +: QW];
                    s_axis_rq_tkeep  = req_tkeep[gidx*KW +: KW];
                    s_axis_rq_tlast  = req_tlast[gidx];
                    s_axis_rq_tvalid = req_tvalid[gidx];
                    if (sop)
                        s_axis_rq_tdata[RQ_TAG_OFF+OWN_LSB +: OWN_W]
                            = OWN_W'(gidx);
                    for (int i = 0; i < N_REQ; i++)
                        req_tready[i] = (gidx == PW'(i))
                                      & s_axis_rq_tready[0];
                    rq_acc = s_axis_rq_tvalid & s_axis_rq_tready[0];
                    if (rq_acc && s_axis_rq_tlast) rq_state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            rq_state <= IDLE;
            rc_state <= RC_IDLE;
        end else begin
            rq_state <= rq_state_d;
            rc_state <= rc_state_d;
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            grant_q <= '0;
            gidx    <= '0;
            ptr     <= '0;
            sop     <= 1'b0;
        end else if (rq_state == IDLE) begin
            if (|req_tvalid) begin
                grant_q <= pick;
                gidx    <= pick_idx;
                sop     <= 1'b1;
            end
        end else if (rq_acc) begin
            sop <= 1'b0;
            if (s_axis_rq_tlast) begin
                grant_q <= '0;
                ptr     <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    // RC path: owner comes from the sop beat, then from the latch
    always_comb begin
        rc_state_d       = rc_state;
        rc_own           = (rc_state == RC_IDLE)
                         ? m_axis_rc_tdata[RC_TAG_OFF+OWN_LSB +: OWN_W]
                         : own_q;
        rc_mis           = int'(rc_own) >= N_REQ;
        rc_tvalid        = '0;
        m_axis_rc_tready = 1'b0;
        rc_misroute      = 1'b0;
        rc_acc           = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rc_own == OWN_W'(i)) begin
                    rc_tvalid[i]     = m_axis_rc_tvalid;
                    m_axis_rc_tready = rc_tready[i];
                end
            end
            // Unowned packets are drained so the core never stalls
            if (rc_mis) m_axis_rc_tready = 1'b1;
            rc_misroute = (rc_state == RC_IDLE) & m_axis_rc_tvalid & rc_mis;
            rc_acc      = m_axis_rc_tvalid & m_axis_rc_tready;
            unique case (rc_state)
                RC_IDLE: if (rc_acc && !m_axis_rc_tlast) rc_state_d = RC_PASS;
                RC_PASS: if (rc_acc && m_axis_rc_tlast)  rc_state_d = RC_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst)
            own_q <= '0;
        else if (rc_state == RC_IDLE && rc_acc)
            own_q <= rc_own;
    end

endmodule
